lsq_dcache_ctrl: RTL and testbench
==================================

Name: lsq_dcache_ctrl

Overview:
Sequencing controller between the head of the load/store memory queue and the single dcache port. It issues one request per queue-head entry and holds it until the dcache responds. It generates byte masks and aligned store data, and aligns and sign-extends load data. It produces the queue dequeue pulse, the load writeback broadcast and a store-complete pulse.

Parameters:
PHYS_W, 6, physical register index width
ROB_W, 6, ROB index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
head_valid  in  1  queue head entry valid
head_addr_ready  in  1  head effective address computed
head_is_store  in  1  1 = store, 0 = load
head_funct3  in  3  RV32I load/store funct3
head_addr  in  32  head effective address
head_wdata  in  32  store source data (unshifted)
head_pd  in  PHYS_W  load destination physical register
head_rob  in  ROB_W  head ROB index
rob_commit_idx  in  ROB_W  ROB entry currently at commit
flush  in  1  pipeline flush
dmem_addr  out  32  word-aligned dcache address
dmem_rmask  out  4  read byte mask
dmem_wmask  out  4  write byte mask
dmem_wdata  out  32  lane-shifted store data
dmem_rdata  in  32  dcache read data
dmem_resp  in  1  dcache response, single-cycle pulse
deq  out  1  dequeue pulse to memory queue
wb_valid  out  1  load result valid
wb_pd  out  PHYS_W  load destination
wb_rob  out  ROB_W  load ROB index
wb_data  out  32  extended load data
store_done  out  1  store completed pulse
misalign  out  1  accompanies deq; access was misaligned

Behaviour:
- States: IDLE, WAIT, DONE. All outputs are registered.
- Reset (async) sets state IDLE and all outputs 0. A dcache request in progress is abandoned immediately.
- Issue condition, evaluated in IDLE: head_valid && head_addr_ready && (!head_is_store || head_rob == rob_commit_idx) && !flush.
- On issue, latch is_store, funct3, addr[1:0], pd and rob.
- Aligned access on issue:
  - Next cycle, drive dmem_addr = {addr[31:2],2'b00}.
  - Mask: byte (funct3 x00) = 4'b0001 << addr[1:0]; half (x01) = 4'b0011 << addr[1:0]; word (010) = 4'b1111.
  - The mask goes on dmem_rmask for loads or dmem_wmask for stores; the other mask is 0.
  - dmem_wdata = head_wdata << (8*addr[1:0]).
  - Go to WAIT.
- Misaligned (half with addr[0]=1, or word with addr[1:0]!=0): no dcache request. Go directly to DONE with misalign=1, wb_data=0.
- WAIT: hold all dmem_* signals stable until dmem_resp. On the dmem_resp cycle:
  - Clear the masks next edge.
  - Compute load data: shift dmem_rdata right by 8*addr[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - Go to DONE.
- DONE, one cycle:
  - deq=1.
  - Load: wb_valid=1 with wb_pd/wb_rob/wb_data.
  - Store: store_done=1.
  - Next state IDLE. No issue occurs in DONE, so the queue head can advance before re-evaluation.
- Throughput: at most one access per 3 cycles (issue, response, DONE) for a zero-wait dcache.
- Flush:
  - In IDLE: suppresses issue.
  - In WAIT: sets a drop flag. The request is held until dmem_resp, then DONE emits no deq/wb_valid/store_done, and the drop flag clears.
  - In DONE: suppresses wb_valid/store_done/deq that cycle.
- Unknown funct3 (011, 11x): treated as word.
- head_* inputs may change after issue; only latched values are used.

Test Plan:
- Load LW, addr 0x1000, rdata 0xDEADBEEF, resp 2 cycles after request → dmem_rmask=1111 and dmem_addr=0x1000 held 2 cycles; DONE: deq=1, wb_valid=1, wb_data=0xDEADBEEF, correct pd/rob.
- LB addr 0x1003, rdata 0x80112233 → rmask=1000, wb_data=0xFFFFFF80. LBU same → 0x00000080. LH addr 0x1002 → rmask=1100, wb_data=0xFFFF8011.
- SB addr 0x2001, wdata 0x000000AB, head_rob=5: rob_commit_idx=4 → no request; rob_commit_idx=5 → wmask=0010, wdata=0x0000AB00; after resp → store_done=1, deq=1, wb_valid=0.
- LW addr 0x3002 → no dmem request; DONE with misalign=1, deq=1, wb_data=0.
- Flush asserted in WAIT → request held until resp; then no deq/wb_valid; back to IDLE.
- Reset asserted in WAIT → dmem masks and all outputs 0 immediately (async); state IDLE; a later resp pulse is ignored.

Source files
------------

// File: rtl/lsq_dcache_ctrl_if.sv
// Single-port dcache bus between the LSQ head sequencer (master) and the dcache (slave).
interface lsq_dcache_ctrl_if;
  logic [31:0] addr;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp;

  modport master (output addr, rmask, wmask, wdata, input rdata, resp);
  modport slave  (input addr, rmask, wmask, wdata, output rdata, resp);
endinterface

// File: rtl/lsq_dcache_ctrl.sv
// Issues one dcache access per memory-queue head entry, holds it until the response,
// then emits dequeue plus load writeback or store-complete for one cycle.
module lsq_dcache_ctrl #(
  parameter int PHYS_W = 6,
  parameter int ROB_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              head_valid,
  input  logic              head_addr_ready,
  input  logic              head_is_store,
  input  logic [2:0]        head_funct3,
  input  logic [31:0]       head_addr,
  input  logic [31:0]       head_wdata,
  input  logic [PHYS_W-1:0] head_pd,
  input  logic [ROB_W-1:0]  head_rob,
  input  logic [ROB_W-1:0]  rob_commit_idx,
  input  logic              flush,
  lsq_dcache_ctrl_if.master dmem,
  output logic              deq,
  output logic              wb_valid,
  output logic [PHYS_W-1:0] wb_pd,
  output logic [ROB_W-1:0]  wb_rob,
  output logic [31:0]       wb_data,
  output logic              store_done,
  output logic              misalign
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       addr_reg, addr_next, wdata_reg, wdata_next;
  logic [3:0]        rmask_reg, rmask_next, wmask_reg, wmask_next;
  logic              deq_reg, deq_next, wb_valid_reg, wb_valid_next;
  logic              store_done_reg, store_done_next, misalign_reg, misalign_next;
  logic [PHYS_W-1:0] wb_pd_reg, wb_pd_next, pd_reg, pd_next;
  logic [ROB_W-1:0]  wb_rob_reg, wb_rob_next, rob_reg, rob_next;
  logic [31:0]       wb_data_reg, wb_data_next;
  logic              is_store_reg, is_store_next, drop_reg, drop_next;
  logic [2:0]        funct3_reg, funct3_next;
  logic [1:0]        off_reg, off_next;

  logic        issue, head_mis, dropping;
  logic [3:0]  head_mask;
  logic [31:0] rdata_shifted, load_data;

  // funct3[1:0] selects size: 00 byte, 01 half, anything else is a word access
  always_comb begin
    head_mask = 4'b1111;
    head_mis  = 1'b0;
    case (head_funct3[1:0])
      2'b00: head_mask = 4'b0001 << head_addr[1:0];
      2'b01: begin
        head_mask = 4'b0011 << head_addr[1:0];
        head_mis  = head_addr[0];
      end
      default: head_mis = (head_addr[1:0] != 2'b00);
    endcase
  end

  assign issue = head_valid && head_addr_ready && !flush &&
                 (!head_is_store || head_rob == rob_commit_idx);

  assign rdata_shifted = dmem.rdata >> {off_reg, 3'b000};

  always_comb begin
    load_data = rdata_shifted;
    case (funct3_reg[1:0])
      2'b00:   load_data = funct3_reg[2] ? {24'd0, rdata_shifted[7:0]}
                                         : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_data = funct3_reg[2] ? {16'd0, rdata_shifted[15:0]}
                                         : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    rmask_next      = rmask_reg;
    wmask_next      = wmask_reg;
    deq_next        = 1'b0;
    wb_valid_next   = 1'b0;
    store_done_next = 1'b0;
    misalign_next   = 1'b0;
    wb_pd_next      = wb_pd_reg;
    wb_rob_next     = wb_rob_reg;
    wb_data_next    = wb_data_reg;
    pd_next         = pd_reg;
    rob_next        = rob_reg;
    is_store_next   = is_store_reg;
    funct3_next     = funct3_reg;
    off_next        = off_reg;
    drop_next       = drop_reg;
    dropping        = drop_reg || flush;
    case (state_reg)
      IDLE: begin
        if (issue) begin
          is_store_next = head_is_store;
          funct3_next   = head_funct3;
          off_next      = head_addr[1:0];
          pd_next       = head_pd;
          rob_next      = head_rob;
          drop_next     = 1'b0;
          if (head_mis) begin
            // Misaligned access never reaches the dcache; retire it straight away
            state_next      = DONE;
            deq_next        = 1'b1;
            misalign_next   = 1'b1;
            wb_valid_next   = !head_is_store;
            store_done_next = head_is_store;
            wb_pd_next      = head_pd;
            wb_rob_next     = head_rob;
            wb_data_next    = 32'd0;
          end else begin
            state_next = WAIT;
            addr_next  = {head_addr[31:2], 2'b00};
            wdata_next = head_wdata << {head_addr[1:0], 3'b000};
            rmask_next = head_is_store ? 4'b0000 : head_mask;
            wmask_next = head_is_store ? head_mask : 4'b0000;
          end
        end
      end
      WAIT: begin
        if (flush) drop_next = 1'b1;
        if (dmem.resp) begin
          state_next      = DONE;
          rmask_next      = 4'b0000;
          wmask_next      = 4'b0000;
          drop_next       = 1'b0;
          deq_next        = !dropping;
          wb_valid_next   = !dropping && !is_store_reg;
          store_done_next = !dropping && is_store_reg;
          wb_pd_next      = pd_reg;
          wb_rob_next     = rob_reg;
          if (!is_store_reg) wb_data_next = load_data;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rmask_reg      <= '0;
      wmask_reg      <= '0;
      deq_reg        <= 1'b0;
      wb_valid_reg   <= 1'b0;
      store_done_reg <= 1'b0;
      misalign_reg   <= 1'b0;
      wb_pd_reg      <= '0;
      wb_rob_reg     <= '0;
      wb_data_reg    <= '0;
      pd_reg         <= '0;
      rob_reg        <= '0;
      is_store_reg   <= 1'b0;
      funct3_reg     <= '0;
      off_reg        <= '0;
      drop_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      rmask_reg      <= rmask_next;
      wmask_reg      <= wmask_next;
      deq_reg        <= deq_next;
      wb_valid_reg   <= wb_valid_next;
      store_done_reg <= store_done_next;
      misalign_reg   <= misalign_next;
      wb_pd_reg      <= wb_pd_next;
      wb_rob_reg     <= wb_rob_next;
      wb_data_reg    <= wb_data_next;
      pd_reg         <= pd_next;
      rob_reg        <= rob_next;
      is_store_reg   <= is_store_next;
      funct3_reg     <= funct3_next;
      off_reg        <= off_next;
      drop_reg       <= drop_next;
    end
  end

  assign dmem.addr  = addr_reg;
  assign dmem.wdata = wdata_reg;
  assign dmem.rmask = rmask_reg;
  assign dmem.wmask = wmask_reg;
  // Retirement pulses only ever rise in DONE, so a flush there squashes them outright
  assign deq        = deq_reg && !flush;
  assign wb_valid   = wb_valid_reg && !flush;
  assign store_done = store_done_reg && !flush;
  assign misalign   = misalign_reg && !flush;
  assign wb_pd      = wb_pd_reg;
  assign wb_rob     = wb_rob_reg;
  assign wb_data    = wb_data_reg;

endmodule

// File: tb/tb_lsq_dcache_ctrl.sv
// Randomized transaction-level bench for lsq_dcache_ctrl with a size/offset reference model.
module tb_lsq_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        head_valid, head_addr_ready, head_is_store, flush;
  logic [2:0]  head_funct3;
  logic [31:0] head_addr, head_wdata;
  logic [5:0]  head_pd, head_rob, rob_commit_idx;
  logic        deq, wb_valid, store_done, misalign;
  logic [5:0]  wb_pd, wb_rob;
  logic [31:0] wb_data;
  int          err_cnt = 0;
  int          chk_cnt = 0;

  lsq_dcache_ctrl_if dbus ();

  lsq_dcache_ctrl #(.PHYS_W(6), .ROB_W(6)) dut (
    .clk(clk), .rst(rst),
    .head_valid(head_valid), .head_addr_ready(head_addr_ready),
    .head_is_store(head_is_store), .head_funct3(head_funct3),
    .head_addr(head_addr), .head_wdata(head_wdata),
    .head_pd(head_pd), .head_rob(head_rob),
    .rob_commit_idx(rob_commit_idx), .flush(flush),
    .dmem(dbus),
    .deq(deq), .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_rob(wb_rob),
    .wb_data(wb_data), .store_done(store_done), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fmode: 0 none, 1 flush during WAIT, 2 flush during DONE
  task automatic run_txn(input bit st, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit [5:0] pd, input bit [5:0] rob,
                         input bit [31:0] rd, input int lat, input int fmode_in,
                         input int cdelay);
    int          sz, fmode;
    bit          mis, drop;
    bit [31:0]   m32, ld, emask, exp_addr, exp_wdata;
    bit [3:0]    m;
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis   = (a % sz) != 0;
    fmode = (mis && fmode_in == 1) ? 0 : fmode_in;
    m32   = ((32'd1 << sz) - 1) << (a % 4);
    m     = m32[3:0];
    exp_addr  = a - (a % 4);
    exp_wdata = wd << (8 * (a % 4));
    emask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    ld    = (rd >> (8 * (a % 4))) & emask;
    if (sz < 4 && !f3[2] && ((ld >> (8 * sz - 1)) & 1) == 1) ld = ld | ~emask;
    drop = (fmode != 0);

    head_valid = 1'b1; head_addr_ready = 1'b1; head_is_store = st;
    head_funct3 = f3; head_addr = a; head_wdata = wd; head_pd = pd; head_rob = rob;
    rob_commit_idx = (st && cdelay > 0) ? rob + 6'd1 : rob;
    if (st) begin
      for (int i = 0; i < cdelay; i++) begin
        tick();
        check("uncommitted_store_mask", {24'd0, dbus.rmask, dbus.wmask}, 32'd0);
        check("uncommitted_store_deq", {31'd0, deq}, 32'd0);
      end
    end
    rob_commit_idx = rob;
    tick();
    head_valid = 1'b0; head_is_store = $urandom; head_funct3 = $urandom;
    head_addr = $urandom; head_wdata = $urandom; head_pd = $urandom; head_rob = $urandom;

    if (!mis) begin
      check("issue_addr", dbus.addr, exp_addr);
      check("issue_rmask", {28'd0, dbus.rmask}, st ? 32'd0 : {28'd0, m});
      check("issue_wmask", {28'd0, dbus.wmask}, st ? {28'd0, m} : 32'd0);
      if (st) check("issue_wdata", dbus.wdata, exp_wdata);
      if (fmode == 1) flush = 1'b1;
      for (int i = 0; i < lat; i++) begin
        tick();
        flush = 1'b0;
        check("hold_addr", dbus.addr, exp_addr);
        check("hold_mask", {24'd0, dbus.rmask, dbus.wmask}, st ? {28'd0, m} : {24'd0, m, 4'd0});
        check("hold_deq", {31'd0, deq}, 32'd0);
      end
      dbus.rdata = rd; dbus.resp = 1'b1;
      tick();
      dbus.resp = 1'b0; dbus.rdata = $urandom; flush = 1'b0;
    end

    if (fmode == 2) begin
      flush = 1'b1;
      #1;
    end
    check("done_deq", {31'd0, deq}, {31'd0, !drop});
    check("done_wb_valid", {31'd0, wb_valid}, {31'd0, !drop && !st});
    check("done_store_done", {31'd0, store_done}, {31'd0, !drop && st});
    check("done_misalign", {31'd0, misalign}, {31'd0, mis && !drop});
    check("done_masks", {24'd0, dbus.rmask, dbus.wmask}, 32'd0);
    if (!st && !drop) begin
      check("wb_data", wb_data, mis ? 32'd0 : ld);
      check("wb_pd", {26'd0, wb_pd}, {26'd0, pd});
      check("wb_rob", {26'd0, wb_rob}, {26'd0, rob});
    end
    flush = 1'b0;
    tick();
    check("idle_deq", {31'd0, deq}, 32'd0);
    $display("txn st=%0d f3=%0d addr=%h wdata=%h rdata=%h lat=%0d fmode=%0d mis=%0d exp_ld=%h",
             st, f3, a, wd, rd, lat, fmode, mis, ld);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; head_valid = 1'b0; head_addr_ready = 1'b0;
    head_is_store = 1'b0; head_funct3 = 3'd0; head_addr = 32'd0; head_wdata = 32'd0;
    head_pd = 6'd0; head_rob = 6'd0; rob_commit_idx = 6'd0;
    dbus.rdata = 32'd0; dbus.resp = 1'b0;
    repeat (2) tick();
    check("reset_deq", {31'd0, deq}, 32'd0);
    check("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("reset_masks", {24'd0, dbus.rmask, dbus.wmask}, 32'd0);
    check("reset_addr", dbus.addr, 32'd0);
    rst = 1'b0;
    tick();

    // Directed cases from the intended use
    run_txn(1'b0, 3'b010, 32'h1000, 32'h0, 6'd9, 6'd3, 32'hDEAD_BEEF, 1, 0, 0);
    run_txn(1'b0, 3'b000, 32'h1003, 32'h0, 6'd1, 6'd2, 32'h8011_2233, 0, 0, 0);
    run_txn(1'b0, 3'b100, 32'h1003, 32'h0, 6'd1, 6'd2, 32'h8011_2233, 0, 0, 0);
    run_txn(1'b0, 3'b001, 32'h1002, 32'h0, 6'd4, 6'd7, 32'h8011_2233, 0, 0, 0);
    run_txn(1'b1, 3'b000, 32'h2001, 32'hAB, 6'd0, 6'd5, 32'h0, 1, 0, 2);
    run_txn(1'b0, 3'b010, 32'h3002, 32'h0, 6'd6, 6'd8, 32'h0, 0, 0, 0);
    run_txn(1'b0, 3'b010, 32'h4000, 32'h0, 6'd6, 6'd8, 32'h1234_5678, 2, 1, 0);
    run_txn(1'b1, 3'b010, 32'h4004, 32'h55AA, 6'd6, 6'd8, 32'h0, 0, 2, 0);

    // Flush in IDLE blocks issue
    head_valid = 1'b1; head_addr_ready = 1'b1; head_is_store = 1'b0;
    head_funct3 = 3'b010; head_addr = 32'h5000; flush = 1'b1;
    tick();
    check("idle_flush_mask", {28'd0, dbus.rmask}, 32'd0);
    head_valid = 1'b0; flush = 1'b0;
    tick();

    for (int n = 0; n < 80; n++) begin
      bit [31:0] a;
      int        fm;
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      fm = $urandom_range(0, 7);
      run_txn(1'($urandom), 3'($urandom), a, $urandom, 6'($urandom), 6'($urandom),
              $urandom, $urandom_range(0, 3), (fm == 6) ? 1 : (fm == 7) ? 2 : 0,
              $urandom_range(0, 2));
    end

    // Async reset while a request is outstanding
    head_valid = 1'b1; head_addr_ready = 1'b1; head_is_store = 1'b0;
    head_funct3 = 3'b010; head_addr = 32'h6000; head_pd = 6'd3; head_rob = 6'd3;
    tick();
    head_valid = 1'b0;
    check("rst_pre_rmask", {28'd0, dbus.rmask}, 32'hF);
    #2 rst = 1'b1;
    #1;
    check("rst_async_rmask", {28'd0, dbus.rmask}, 32'd0);
    check("rst_async_addr", dbus.addr, 32'd0);
    check("rst_async_deq", {31'd0, deq}, 32'd0);
    tick();
    rst = 1'b0;
    dbus.resp = 1'b1; dbus.rdata = 32'hFFFF_FFFF;
    tick();
    dbus.resp = 1'b0;
    tick();
    check("rst_late_resp_deq", {31'd0, deq}, 32'd0);
    check("rst_late_resp_wb", {31'd0, wb_valid}, 32'd0);
    $display("txn reset-in-wait addr=00006000");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
